line_abs_sum_ctrl: RTL and testbench

Sequencing controller for the detection line absolute-sum datapath. It accepts a stream of 128-bit periods (16 signed 8-bit samples each) and feeds each period through a `LineAbsSumCalc` instance, accumulating a per-line sum across a fixed number of beats. At each line end it emits the line sum, a threshold-exceed flag and the line index, and it tracks line position within a frame. It sits between the detection input buffer and the detection decision logic.

---
 rtl/line_abs_sum_ctrl_pkg.sv | 23 ++
 rtl/LineAbsSumCalc.sv | 32 +++
 rtl/line_abs_sum_ctrl.sv | 127 ++++++++++++
 tb/tb_line_abs_sum_ctrl.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/line_abs_sum_ctrl_pkg.sv
// Shared detection-line constants, controller state encoding and the
// accumulator saturation helper.
package line_abs_sum_ctrl_pkg;

  localparam int PERIOD_W           = 128;
  localparam int SAMPLE_W           = 8;
  localparam int SUM_W              = 32;
  localparam int SAMPLES_PER_PERIOD = 16;

  localparam logic [SUM_W-1:0] SUM_MAX = 32'h7FFF_FFFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  // Clamp a widened running sum to the largest positive signed 32-bit value.
  function automatic logic [SUM_W-1:0] saturate(input logic [SUM_W:0] wide);
    return (wide > {1'b0, SUM_MAX}) ? SUM_MAX : wide[SUM_W-1:0];
  endfunction

endpackage

// File: rtl/LineAbsSumCalc.sv
// Combinational datapath: |CurAbsSum| plus the absolute values of the
// sixteen signed samples of one period.
module LineAbsSumCalc
  import line_abs_sum_ctrl_pkg::*;
(
  input  logic [PERIOD_W-1:0]     Period,
  input  logic signed [SUM_W-1:0] CurAbsSum,
  output logic [SUM_W-1:0]        UpdatedAbsSum
);

  logic [SAMPLE_W-1:0] sample;
  logic [SAMPLE_W-1:0] mag;
  logic [SUM_W-1:0]    beat_sum;
  logic [SUM_W-1:0]    cur_mag;

  // Magnitudes are kept unsigned, so -128 (0x80) reads back as +128 and
  // |CurAbsSum| never exceeds 2^31; the 32-bit result therefore cannot wrap.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    sample   = '0;
    mag      = '0;
    beat_sum = '0;
    for (int i = 0; i < SAMPLES_PER_PERIOD; i++) begin
      sample   = Period[i*SAMPLE_W +: SAMPLE_W];
      mag      = sample[SAMPLE_W-1] ? (~sample + SAMPLE_W'(1)) : sample;
      beat_sum = beat_sum + SUM_W'(mag);
    end
    cur_mag       = CurAbsSum[SUM_W-1] ? (~CurAbsSum + SUM_W'(1)) : CurAbsSum;
    UpdatedAbsSum = cur_mag + beat_sum;
  end

endmodule

// File: rtl/line_abs_sum_ctrl.sv
// Line absolute-sum sequencing controller: accumulates BEATS_PER_LINE periods
// per line, presents the saturated sum with a threshold flag, tracks frame position.
module line_abs_sum_ctrl
  import line_abs_sum_ctrl_pkg::*;
#(
  parameter int BEATS_PER_LINE  = 40,
  parameter int LINES_PER_FRAME = 480
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [PERIOD_W-1:0]     in_data,
  input  logic signed [SUM_W-1:0] threshold,
  output logic                    sum_valid,
  input  logic                    sum_ready,
  output logic [SUM_W-1:0]        sum_data,
  output logic                    sum_over,
  output logic [15:0]             line_idx,
  output logic                    frame_done
);

  localparam logic [15:0] LAST_BEAT = 16'(BEATS_PER_LINE - 1);
  localparam logic [15:0] LAST_LINE = 16'(LINES_PER_FRAME - 1);

  state_t                  state_q, state_d;
  logic [SUM_W-1:0]        acc_q, acc_d;
  logic [15:0]             beat_cnt_q, beat_cnt_d;
  logic [15:0]             line_idx_q, line_idx_d;
  logic signed [SUM_W-1:0] thr_q, thr_d;
  logic                    in_ready_q;
  logic                    frame_done_q, frame_done_d;

  logic signed [SUM_W-1:0] calc_cur;
  logic [SUM_W-1:0]        calc_upd;
  logic [SUM_W-1:0]        acc_step;
  logic                    beat_fire;
  logic                    sum_fire;

  // A new line starts from zero, so only ACCUM feeds the running sum back.
  assign calc_cur = (state_q == ACCUM) ? $signed(acc_q) : '0;

  LineAbsSumCalc u_calc (
    .Period        (in_data),
    .CurAbsSum     (calc_cur),
    .UpdatedAbsSum (calc_upd)
  );

  assign acc_step  = saturate({1'b0, calc_upd});
  assign beat_fire = in_valid && in_ready_q && !clear;
  assign sum_fire  = (state_q == HOLD) && sum_ready && !clear;

  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    beat_cnt_d   = beat_cnt_q;
    line_idx_d   = line_idx_q;
    thr_d        = thr_q;
    frame_done_d = 1'b0;

    if (clear) begin
      state_d    = IDLE;
      acc_d      = '0;
      beat_cnt_d = '0;
      line_idx_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (beat_fire) begin
            thr_d      = threshold;
            acc_d      = acc_step;
            beat_cnt_d = 16'd1;
            state_d    = (BEATS_PER_LINE == 1) ? HOLD : ACCUM;
          end
        end
        ACCUM: begin
          if (beat_fire) begin
            acc_d      = acc_step;
            beat_cnt_d = beat_cnt_q + 16'd1;
            if (beat_cnt_q == LAST_BEAT) state_d = HOLD;
          end
        end
        HOLD: begin
          if (sum_fire) begin
            line_idx_d   = (line_idx_q == LAST_LINE) ? 16'd0 : line_idx_q + 16'd1;
            frame_done_d = (line_idx_q == LAST_LINE);
            acc_d        = '0;
            beat_cnt_d   = '0;
            state_d      = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      acc_q        <= '0;
      beat_cnt_q   <= '0;
      line_idx_q   <= '0;
      thr_q        <= '0;
      in_ready_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      beat_cnt_q   <= beat_cnt_d;
      line_idx_q   <= line_idx_d;
      thr_q        <= thr_d;
      in_ready_q   <= (state_d != HOLD);
      frame_done_q <= frame_done_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign sum_valid  = (state_q == HOLD);
  assign sum_data   = sum_valid ? acc_q : '0;
  assign sum_over   = sum_valid && ($signed(acc_q) > thr_q);
  assign line_idx   = line_idx_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_line_abs_sum_ctrl.sv
// Directed bench for line_abs_sum_ctrl with 4 beats per line, 3 lines per frame.
module tb_line_abs_sum_ctrl;

  localparam int BPL = 4;
  localparam int LPF = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic         clear;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic [31:0]  threshold;
  logic         sum_valid;
  logic         sum_ready;
  logic [31:0]  sum_data;
  logic         sum_over;
  logic [15:0]  line_idx;
  logic         frame_done;

  int n_cmp = 0;
  int n_bad = 0;

  logic        r_v, r_o, r_fd;
  logic [31:0] r_d;
  logic [15:0] r_idx;

  line_abs_sum_ctrl #(.BEATS_PER_LINE(BPL), .LINES_PER_FRAME(LPF)) dut (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .threshold  (threshold),
    .sum_valid  (sum_valid),
    .sum_ready  (sum_ready),
    .sum_data   (sum_data),
    .sum_over   (sum_over),
    .line_idx   (line_idx),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [127:0] fill(input logic [7:0] b);
    return {16{b}};
  endfunction

  // Presents one beat at a negedge and returns at the negedge after it is taken.
  task automatic send_beat(input logic [127:0] d);
    int waited = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (in_ready !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (in_ready !== 1'b1) begin
      n_cmp++; n_bad++;
      $display("FAIL beat_accept_timeout: in_ready=%b required 1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_line(input logic [127:0] d, input logic [31:0] thr);
    threshold = thr;
    for (int i = 0; i < BPL; i++) send_beat(d);
  endtask

  // Captures the presented result, completes the handshake, then samples frame_done.
  task automatic take_result(output logic v, output logic [31:0] d, output logic o,
                             output logic [15:0] idx, output logic fd);
    v   = sum_valid;
    d   = sum_data;
    o   = sum_over;
    idx = line_idx;
    sum_ready = 1'b1;
    @(negedge clk);
    sum_ready = 1'b0;
    fd  = frame_done;
  endtask

  task automatic test_reset;
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; sum_ready = 1'b0;
    in_data = '0; threshold = '0;
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b0)   begin n_bad++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
    n_cmp++; if (sum_valid !== 1'b0)  begin n_bad++; $display("FAIL rst_sum_valid: got %b want 0", sum_valid); end
    n_cmp++; if (sum_data !== 32'd0)  begin n_bad++; $display("FAIL rst_sum_data: got %0d want 0", sum_data); end
    n_cmp++; if (sum_over !== 1'b0)   begin n_bad++; $display("FAIL rst_sum_over: got %b want 0", sum_over); end
    n_cmp++; if (line_idx !== 16'd0)  begin n_bad++; $display("FAIL rst_line_idx: got %0d want 0", line_idx); end
    n_cmp++; if (frame_done !== 1'b0) begin n_bad++; $display("FAIL rst_frame_done: got %b want 0", frame_done); end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1)   begin n_bad++; $display("FAIL rst_release_in_ready: got %b want 1", in_ready); end
  endtask

  // 16 samples of +1 per beat: 4 beats -> 64, strictly above 63.
  task automatic test_basic;
    threshold = 32'd63;
    for (int i = 0; i < BPL - 1; i++) send_beat(fill(8'h01));
    n_cmp++; if (sum_valid !== 1'b0) begin n_bad++; $display("FAIL basic_early_valid: got %b want 0", sum_valid); end
    send_beat(fill(8'h01));
    take_result(r_v, r_d, r_o, r_idx, r_fd);
    n_cmp++; if (r_v !== 1'b1)    begin n_bad++; $display("FAIL basic_latency: sum_valid=%b want 1", r_v); end
    n_cmp++; if (r_d !== 32'd64)  begin n_bad++; $display("FAIL basic_sum: got %0d want 64", r_d); end
    n_cmp++; if (r_o !== 1'b1)    begin n_bad++; $display("FAIL basic_over: got %b want 1", r_o); end
    n_cmp++; if (r_idx !== 16'd0) begin n_bad++; $display("FAIL basic_idx: got %0d want 0", r_idx); end
    n_cmp++; if (r_fd !== 1'b0)   begin n_bad++; $display("FAIL basic_fd: got %b want 0", r_fd); end
    n_cmp++; if (line_idx !== 16'd1) begin n_bad++; $display("FAIL basic_idx_next: got %0d want 1", line_idx); end
  endtask

  // 0x80/0x7F alternating: 8*128 + 8*127 = 2040 per beat, 8160 per line.
  task automatic test_extreme;
    send_line({8{8'h7F, 8'h80}}, 32'd2000);
    take_result(r_v, r_d, r_o, r_idx, r_fd);
    n_cmp++; if (r_d !== 32'd8160) begin n_bad++; $display("FAIL ext_sum: got %0d want 8160", r_d); end
    n_cmp++; if (r_o !== 1'b1)     begin n_bad++; $display("FAIL ext_over_2000: got %b want 1", r_o); end
    n_cmp++; if (r_idx !== 16'd1)  begin n_bad++; $display("FAIL ext_idx1: got %0d want 1", r_idx); end
    n_cmp++; if (r_fd !== 1'b0)    begin n_bad++; $display("FAIL ext_fd1: got %b want 0", r_fd); end
    // Threshold equal to the sum; changing it after beat one must have no effect.
    threshold = 32'd8160;
    send_beat({8{8'h7F, 8'h80}});
    threshold = 32'd0;
    for (int i = 1; i < BPL; i++) send_beat({8{8'h7F, 8'h80}});
    take_result(r_v, r_d, r_o, r_idx, r_fd);
    n_cmp++; if (r_d !== 32'd8160) begin n_bad++; $display("FAIL ext_sum2: got %0d want 8160", r_d); end
    n_cmp++; if (r_o !== 1'b0)     begin n_bad++; $display("FAIL ext_over_equal: got %b want 0", r_o); end
    n_cmp++; if (r_idx !== 16'd2)  begin n_bad++; $display("FAIL ext_idx2: got %0d want 2", r_idx); end
    n_cmp++; if (r_fd !== 1'b1)    begin n_bad++; $display("FAIL frame_done_pulse: got %b want 1", r_fd); end
    @(negedge clk);
    n_cmp++; if (frame_done !== 1'b0) begin n_bad++; $display("FAIL frame_done_width: got %b want 0", frame_done); end
    n_cmp++; if (line_idx !== 16'd0)  begin n_bad++; $display("FAIL frame_wrap_idx: got %0d want 0", line_idx); end
  endtask

  // 16*3*4 = 192; held for 10 cycles with beats offered that must not be taken.
  task automatic test_backpressure;
    send_line(fill(8'h03), 32'd191);
    in_valid = 1'b1;
    in_data  = fill(8'h7F);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_cmp++; if (sum_valid !== 1'b1)   begin n_bad++; $display("FAIL bp_valid[%0d]: got %b want 1", i, sum_valid); end
      n_cmp++; if (sum_data !== 32'd192) begin n_bad++; $display("FAIL bp_data[%0d]: got %0d want 192", i, sum_data); end
      n_cmp++; if (in_ready !== 1'b0)    begin n_bad++; $display("FAIL bp_in_ready[%0d]: got %b want 0", i, in_ready); end
    end
    in_valid = 1'b0;
    take_result(r_v, r_d, r_o, r_idx, r_fd);
    n_cmp++; if (r_d !== 32'd192) begin n_bad++; $display("FAIL bp_sum: got %0d want 192", r_d); end
    n_cmp++; if (r_o !== 1'b1)    begin n_bad++; $display("FAIL bp_over: got %b want 1", r_o); end
    n_cmp++; if (r_idx !== 16'd0) begin n_bad++; $display("FAIL bp_idx: got %0d want 0", r_idx); end
    n_cmp++; if (line_idx !== 16'd1) begin n_bad++; $display("FAIL bp_idx_next: got %0d want 1", line_idx); end
    send_line(fill(8'h01), 32'd64);
    take_result(r_v, r_d, r_o, r_idx, r_fd);
    n_cmp++; if (r_d !== 32'd64) begin n_bad++; $display("FAIL bp_after_sum: got %0d want 64", r_d); end
    n_cmp++; if (r_o !== 1'b0)   begin n_bad++; $display("FAIL bp_after_over: got %b want 0", r_o); end
  endtask

  // Lines started right after the handshake; -16 samples vs negative threshold.
  task automatic test_back_to_back;
    send_line(fill(8'hF0), -32'sd5);
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_hold_ready: got %b want 0", in_ready); end
    take_result(r_v, r_d, r_o, r_idx, r_fd);
    n_cmp++; if (r_d !== 32'd1024) begin n_bad++; $display("FAIL b2b_sum1: got %0d want 1024", r_d); end
    n_cmp++; if (r_o !== 1'b1)     begin n_bad++; $display("FAIL b2b_over1: got %b want 1", r_o); end
    n_cmp++; if (r_idx !== 16'd2)  begin n_bad++; $display("FAIL b2b_idx1: got %0d want 2", r_idx); end
    n_cmp++; if (r_fd !== 1'b1)    begin n_bad++; $display("FAIL b2b_fd1: got %b want 1", r_fd); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready_after: got %b want 1", in_ready); end
    send_line(fill(8'h01), 32'd100);
    take_result(r_v, r_d, r_o, r_idx, r_fd);
    n_cmp++; if (r_d !== 32'd64)  begin n_bad++; $display("FAIL b2b_sum2: got %0d want 64", r_d); end
    n_cmp++; if (r_o !== 1'b0)    begin n_bad++; $display("FAIL b2b_over2: got %b want 0", r_o); end
    n_cmp++; if (r_idx !== 16'd0) begin n_bad++; $display("FAIL b2b_idx2: got %0d want 0", r_idx); end
    n_cmp++; if (r_fd !== 1'b0)   begin n_bad++; $display("FAIL b2b_fd2: got %b want 0", r_fd); end
  endtask

  task automatic test_clear;
    threshold = 32'd200;
    send_beat(fill(8'h01));
    send_beat(fill(8'h01));
    clear = 1'b1; in_valid = 1'b1; in_data = fill(8'h7F);
    @(negedge clk);
    clear = 1'b0; in_valid = 1'b0;
    n_cmp++; if (sum_valid !== 1'b0) begin n_bad++; $display("FAIL clr_valid: got %b want 0", sum_valid); end
    n_cmp++; if (line_idx !== 16'd0) begin n_bad++; $display("FAIL clr_idx: got %0d want 0", line_idx); end
    send_line(fill(8'h02), 32'd200);
    take_result(r_v, r_d, r_o, r_idx, r_fd);
    n_cmp++; if (r_d !== 32'd128) begin n_bad++; $display("FAIL clr_sum: got %0d want 128", r_d); end
    n_cmp++; if (r_o !== 1'b0)    begin n_bad++; $display("FAIL clr_over: got %b want 0", r_o); end
    n_cmp++; if (r_idx !== 16'd0) begin n_bad++; $display("FAIL clr_line_idx: got %0d want 0", r_idx); end
    // clear wins over a simultaneous result handshake.
    send_line(fill(8'h01), 32'd0);
    clear = 1'b1; sum_ready = 1'b1;
    @(negedge clk);
    clear = 1'b0; sum_ready = 1'b0;
    n_cmp++; if (sum_valid !== 1'b0)  begin n_bad++; $display("FAIL clr_hold_valid: got %b want 0", sum_valid); end
    n_cmp++; if (line_idx !== 16'd0)  begin n_bad++; $display("FAIL clr_hold_idx: got %0d want 0", line_idx); end
    n_cmp++; if (frame_done !== 1'b0) begin n_bad++; $display("FAIL clr_hold_fd: got %b want 0", frame_done); end
  endtask

  task automatic test_reset_hold;
    send_line(fill(8'h01), 32'd0);
    n_cmp++; if (sum_valid !== 1'b1) begin n_bad++; $display("FAIL rh_pre_valid: got %b want 1", sum_valid); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (sum_valid !== 1'b0) begin n_bad++; $display("FAIL rh_valid: got %b want 0", sum_valid); end
    n_cmp++; if (sum_data !== 32'd0) begin n_bad++; $display("FAIL rh_data: got %0d want 0", sum_data); end
    n_cmp++; if (in_ready !== 1'b0)  begin n_bad++; $display("FAIL rh_ready: got %b want 0", in_ready); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send_line(fill(8'hFF), 32'd64);
    take_result(r_v, r_d, r_o, r_idx, r_fd);
    n_cmp++; if (r_d !== 32'd64)  begin n_bad++; $display("FAIL rh_sum: got %0d want 64", r_d); end
    n_cmp++; if (r_o !== 1'b0)    begin n_bad++; $display("FAIL rh_over: got %b want 0", r_o); end
    n_cmp++; if (r_idx !== 16'd0) begin n_bad++; $display("FAIL rh_idx: got %0d want 0", r_idx); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_extreme;
    test_backpressure;
    test_back_to_back;
    test_clear;
    test_reset_hold;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
